trisc_mem_responder: RTL and testbench

- Memory-side responder for the TRISC controller's memory control strobes.
- Takes the access strobe (C4), write select (C5) and transfer strobe (C42), and performs single-word reads or writes on an internal RAM.
- Registers read data in MDR and forwards it to MDO on transfer.
- Sits between the PC/MDO address mux and the ACC/MDI datapath; supports programmable wait states and test preload.

---
 rtl/trisc_mem_responder.sv | 146 ++++++++++++++
 tb/tb_trisc_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trisc_mem_responder.sv
// Memory-side responder for the TRISC memory strobes: single-word RAM reads/writes
// with optional wait states, MDR capture, MDO transfer and test preload.
module trisc_mem_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              CLR_n,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] MDI,
    input  logic              C4,
    input  logic              C5,
    input  logic              C42,
    input  logic              LD_EN,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic [DATA_W-1:0] MDR,
    output logic [DATA_W-1:0] MDO,
    output logic              BUSY,
    output logic              DONE,
    output logic              LATE
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                c4_q;
    logic [ADDR_W-1:0]   a_q;
    logic                w_q;
    logic [DATA_W-1:0]   d_q;

    logic                req;
    logic                cap;
    logic                acc_go;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_wr;
    logic [DATA_W-1:0]   acc_data;
    logic                ld_go;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign req  = C4 & ~c4_q;
    assign BUSY = (state == S_WAIT);
    assign DONE = (state == S_HOLD);

    // HOLD behaves like IDLE for a new request so back-to-back accesses lose no cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cap      = 1'b0;
        acc_go   = 1'b0;
        acc_addr = a_q;
        acc_wr   = w_q;
        acc_data = d_q;
        ld_go    = 1'b0;
        case (state)
            S_IDLE, S_HOLD: begin
                if (req) begin
                    cap = 1'b1;
                    if (WAIT_STATES == 0) begin
                        acc_go   = 1'b1;
                        acc_addr = ADDR;
                        acc_wr   = C5;
                        acc_data = MDI;
                        state_nx = S_HOLD;
                    end else begin
                        cnt_nx   = CNT_W'(WAIT_STATES - 1);
                        state_nx = S_WAIT;
                    end
                end else begin
                    state_nx = S_IDLE;
                    ld_go    = LD_EN & (state == S_IDLE);
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    acc_go   = 1'b1;
                    state_nx = S_HOLD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Access and preload are mutually exclusive; reset blocks any pending write
    assign mem_we    = CLR_n & ((acc_go & acc_wr) | ld_go);
    assign mem_waddr = ld_go ? LD_ADDR : acc_addr;
    assign mem_wdata = ld_go ? LD_DATA : acc_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            c4_q  <= 1'b0;
            a_q   <= '0;
            w_q   <= 1'b0;
            d_q   <= '0;
            MDR   <= '0;
            MDO   <= '0;
            LATE  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            c4_q  <= C4;
            if (cap) begin
                a_q <= ADDR;
                w_q <= C5;
                d_q <= MDI;
            end
            if (acc_go && !acc_wr) begin
                MDR <= mem[acc_addr];
            end
            // MDO takes the MDR value present before this edge
            if (C42) begin
                if (BUSY) begin
                    LATE <= 1'b1;
                end else begin
                    MDO <= MDR;
                end
            end
        end
    end

endmodule

// File: tb/tb_trisc_mem_responder.sv
// Bench for trisc_mem_responder: three instances (0, 2 and 3 wait states) share stimulus
// and are compared each cycle against a transaction-level reference model.
module tb_trisc_mem_responder;

    localparam int N_INST = 3;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic [3:0] addr = '0;
    logic [7:0] mdi = '0;
    logic       c4 = 1'b0;
    logic       c5 = 1'b0;
    logic       c42 = 1'b0;
    logic       ld_en = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    logic [7:0] mdr_w  [N_INST];
    logic [7:0] mdo_w  [N_INST];
    logic       busy_w [N_INST];
    logic       done_w [N_INST];
    logic       late_w [N_INST];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        trisc_mem_responder #(
            .ADDR_W(4),
            .DATA_W(8),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) dut (
            .clk(clk),
            .CLR_n(clr_n),
            .ADDR(addr),
            .MDI(mdi),
            .C4(c4),
            .C5(c5),
            .C42(c42),
            .LD_EN(ld_en),
            .LD_ADDR(ld_addr),
            .LD_DATA(ld_data),
            .MDR(mdr_w[g]),
            .MDO(mdo_w[g]),
            .BUSY(busy_w[g]),
            .DONE(done_w[g]),
            .LATE(late_w[g])
        );
    end

    // Reference model: a pending access is a countdown of cycles until it lands
    logic [7:0] m_mem  [N_INST][16];
    logic [7:0] m_mdr  [N_INST];
    logic [7:0] m_mdo  [N_INST];
    logic       m_late [N_INST];
    logic       m_done [N_INST];
    logic       m_pend [N_INST];
    int         m_left [N_INST];
    logic [3:0] m_pa   [N_INST];
    logic       m_pw   [N_INST];
    logic [7:0] m_pd   [N_INST];
    logic       m_c4q  [N_INST];

    task automatic model_reset();
        for (int i = 0; i < N_INST; i++) begin
            m_mdr[i]  = '0;
            m_mdo[i]  = '0;
            m_late[i] = 1'b0;
            m_done[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_left[i] = 0;
            m_c4q[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        logic       req;
        logic       idle_now;
        logic       new_done;
        logic       do_acc;
        logic [3:0] a;
        logic       w;
        logic [7:0] d;
        req      = c4 && !m_c4q[i];
        idle_now = !m_pend[i] && !m_done[i];
        new_done = 1'b0;
        do_acc   = 1'b0;
        a = m_pa[i];
        w = m_pw[i];
        d = m_pd[i];
        if (c42) begin
            if (m_pend[i]) m_late[i] = 1'b1;
            else           m_mdo[i]  = m_mdr[i];
        end
        if (m_pend[i]) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
                do_acc    = 1'b1;
                m_pend[i] = 1'b0;
            end
        end else if (req) begin
            if (ws_of(i) == 0) begin
                do_acc = 1'b1;
                a = addr;
                w = c5;
                d = mdi;
            end else begin
                m_pend[i] = 1'b1;
                m_left[i] = ws_of(i);
                m_pa[i]   = addr;
                m_pw[i]   = c5;
                m_pd[i]   = mdi;
            end
        end else if (ld_en && idle_now) begin
            m_mem[i][ld_addr] = ld_data;
        end
        if (do_acc) begin
            new_done = 1'b1;
            if (w) m_mem[i][a] = d;
            else   m_mdr[i]    = m_mem[i][a];
        end
        m_done[i] = new_done;
        m_c4q[i]  = c4;
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) model_reset();
        else for (int i = 0; i < N_INST; i++) model_edge(i);
    end

    task automatic chk(input string name, input int i, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s[%0d]: got %h, expected %h", name, i, got, exp);
        end
    endtask

    task automatic check_output();
        for (int i = 0; i < N_INST; i++) begin
            chk("model_mdr", i, mdr_w[i], m_mdr[i]);
            chk("model_mdo", i, mdo_w[i], m_mdo[i]);
            chk("model_busy", i, {7'd0, busy_w[i]}, {7'd0, m_pend[i]});
            chk("model_done", i, {7'd0, done_w[i]}, {7'd0, m_done[i]});
            chk("model_late", i, {7'd0, late_w[i]}, {7'd0, m_late[i]});
        end
    endtask

    task automatic apply_stimulus(input logic s_c4, input logic s_c5, input logic s_c42,
                                  input logic [3:0] s_addr, input logic [7:0] s_mdi);
        c4   = s_c4;
        c5   = s_c5;
        c42  = s_c42;
        addr = s_addr;
        mdi  = s_mdi;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_output();
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        ld_en = 1'b0;
        clr_n = 1'b0;
        #1;
        for (int i = 0; i < N_INST; i++) begin
            chk("reset_mdr", i, mdr_w[i], 8'h00);
            chk("reset_mdo", i, mdo_w[i], 8'h00);
            chk("reset_flags", i, {5'd0, busy_w[i], done_w[i], late_w[i]}, 8'h00);
        end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    typedef struct {
        logic       c4;
        logic       c5;
        logic       c42;
        logic [3:0] addr;
        logic [7:0] mdi;
        logic [7:0] exp_mdr;
        logic [7:0] exp_mdo;
        logic       exp_done;
    } vec_t;

    vec_t vecs [8];
    int   done_cnt [N_INST];

    initial begin
        // Outputs of the zero-wait instance after each edge
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 8'hA5, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, 8'hA5, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'd5, 8'h3C, 8'hA5, 8'hA5, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'd5, 8'h00, 8'hA5, 8'hA5, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'd5, 8'h00, 8'h3C, 8'hA5, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 4'd5, 8'h00, 8'h3C, 8'h3C, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h3C, 8'h3C, 1'b0};

        for (int i = 0; i < N_INST; i++)
            for (int k = 0; k < 16; k++) m_mem[i][k] = '0;
        #2;
        do_reset();

        $display("[TB] preload");
        for (int k = 0; k < 16; k++) begin
            ld_en   = 1'b1;
            ld_addr = 4'(k);
            ld_data = (k == 3) ? 8'hA5 : (k == 2) ? 8'h11 : (k == 7) ? 8'h00 : 8'(8'h10 + k);
            tick();
        end
        ld_en = 1'b0;

        $display("[TB] read / write-read vectors");
        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v].c4, vecs[v].c5, vecs[v].c42, vecs[v].addr, vecs[v].mdi);
            tick();
            chk("vec_mdr", v, mdr_w[0], vecs[v].exp_mdr);
            chk("vec_mdo", v, mdo_w[0], vecs[v].exp_mdo);
            chk("vec_done", v, {7'd0, done_w[0]}, {7'd0, vecs[v].exp_done});
            chk("vec_busy", v, {7'd0, busy_w[0]}, 8'h00);
        end

        $display("[TB] wait states and late transfer");
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        tick();
        chk("ws3_busy1", 2, {7'd0, busy_w[2]}, 8'h01);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        tick();
        chk("ws3_busy2", 2, {7'd0, busy_w[2]}, 8'h01);
        chk("ws3_late", 2, {7'd0, late_w[2]}, 8'h01);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        chk("ws3_busy3", 2, {7'd0, busy_w[2]}, 8'h01);
        chk("ws3_done_early", 2, {7'd0, done_w[2]}, 8'h00);
        tick();
        chk("ws3_done", 2, {7'd0, done_w[2]}, 8'h01);
        chk("ws3_busy_end", 2, {7'd0, busy_w[2]}, 8'h00);
        chk("ws3_mdr", 2, mdr_w[2], 8'h11);
        chk("ws3_mdo_held", 2, mdo_w[2], 8'h00);
        tick();
        chk("ws3_late_sticky", 2, {7'd0, late_w[2]}, 8'h01);

        $display("[TB] held C4 and preload collision");
        do_reset();
        for (int i = 0; i < N_INST; i++) done_cnt[i] = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd4, 8'h00);
        ld_en   = 1'b1;
        ld_addr = 4'd9;
        ld_data = 8'hEE;
        for (int c = 0; c < 10; c++) begin
            tick();
            ld_en = 1'b0;
            if (c == 4) c4 = 1'b0;
            for (int i = 0; i < N_INST; i++) if (done_w[i]) done_cnt[i]++;
        end
        for (int i = 0; i < N_INST; i++) chk("held_done_count", i, 8'(done_cnt[i]), 8'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
        tick();
        c4 = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        for (int i = 0; i < N_INST; i++) chk("preload_ignored", i, mdr_w[i], 8'h19);

        $display("[TB] reset during wait");
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd7, 8'hFF);
        tick();
        chk("abort_busy", 1, {7'd0, busy_w[1]}, 8'h01);
        do_reset();
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
        tick();
        c4 = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("abort_mem1", 1, mdr_w[1], 8'h00);
        chk("abort_mem2", 2, mdr_w[2], 8'h00);
        chk("ws0_write7", 0, mdr_w[0], 8'hFF);

        $display("[TB] back-to-back through HOLD");
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        tick();
        c4 = 1'b0;
        tick();
        tick();
        chk("b2b_done1", 1, {7'd0, done_w[1]}, 8'h01);
        chk("b2b_mdr1", 1, mdr_w[1], 8'hA5);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        tick();
        chk("b2b_accept", 1, {7'd0, busy_w[1]}, 8'h01);
        c4 = 1'b0;
        tick();
        tick();
        chk("b2b_done2", 1, {7'd0, done_w[1]}, 8'h01);
        chk("b2b_mdr2", 1, mdr_w[1], 8'h11);

        $display("[TB] random traffic");
        do_reset();
        for (int c = 0; c < 800; c++) begin
            apply_stimulus($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                           4'($urandom), 8'($urandom));
            ld_en   = ($urandom_range(0, 4) == 0);
            ld_addr = 4'($urandom);
            ld_data = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
